// File: rtl/rgb_pwm_stage.sv
// rgb_pwm_stage: three-channel PWM output stage of the RGB mixer.
//
// Level sets arrive over a valid/ready handshake into a single-entry pending
// buffer. They are moved to the target registers on a PWM period boundary, or
// on the next cycle while the stage is disabled. Each output is high while the
// period counter is below its channel's active duty.
//
// Optional feature (macro PWM_SLEW_EN): each active duty steps by one toward
// its target on every period wrap instead of jumping to it.
//
// Ports:
//   clk          clock (single domain)
//   reset_n      synchronous active-low reset
//   enable       PWM run enable; when low, counters are held at zero
//   level0..2    requested duty per channel (WIDTH bits)
//   level_valid  level0..2 valid
//   level_ready  pending buffer empty, a level set can be accepted
//   pwm0..2_out  registered PWM outputs (GPIO 14/15/16)
//   sync         one-clk pulse in the cycle the counter first reads 0 (GPIO 17)
module rgb_pwm_stage #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [WIDTH-1:0] level0,
   input  logic [WIDTH-1:0] level1,
   input  logic [WIDTH-1:0] level2,
   input  logic             level_valid,
   output logic             level_ready,
   output logic             pwm0_out,
   output logic             pwm1_out,
   output logic             pwm2_out,
   output logic             sync
);

   localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PreW-1:0]         pre_q, pre_d;
   logic [WIDTH-1:0]        cnt_q, cnt_d;
   logic [2:0][WIDTH-1:0]   pend_q, pend_d;
   logic                    pend_full_q, pend_full_d;
   logic [2:0][WIDTH-1:0]   target_q, target_d;
   logic [2:0][WIDTH-1:0]   active;
   logic [2:0]              pwm_q, pwm_d;
   logic                    sync_q, sync_d;

   logic tick;
   logic wrap;
   logic accept;

   assign tick   = (pre_q == PreW'(PRESCALE - 1));
   assign wrap   = enable && tick && (cnt_q == '1);
   assign accept = level_valid && !pend_full_q;

   assign level_ready = !pend_full_q;
   assign pwm0_out    = pwm_q[0];
   assign pwm1_out    = pwm_q[1];
   assign pwm2_out    = pwm_q[2];
   assign sync        = sync_q;

   // Counters and the pending/target double buffer.
   always_comb begin
      pre_d       = pre_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      target_d    = target_q;

      if (!enable) begin
         pre_d = '0;
         cnt_d = '0;
         // No period to wait for while stopped: drain straight away.
         if (pend_full_q) begin
            target_d    = pend_q;
            pend_full_d = 1'b0;
         end
      end else begin
         if (tick) begin
            pre_d = '0;
            cnt_d = cnt_q + 1'b1;
         end else begin
            pre_d = pre_q + 1'b1;
         end
         if (wrap && pend_full_q) begin
            target_d    = pend_q;
            pend_full_d = 1'b0;
         end
      end

      // Accept only when empty, so a same-cycle wrap never sees this set.
      if (accept) begin
         pend_d      = {level2, level1, level0};
         pend_full_d = 1'b1;
      end
   end

`ifdef PWM_SLEW_EN
   logic [2:0][WIDTH-1:0] active_q, active_d;

   always_comb begin
      active_d = active_q;
      for (int k = 0; k < 3; k++) begin
         if (!enable) begin
            active_d[k] = target_d[k];
         end else if (wrap) begin
            // Step toward the post-update target; equality holds, never overshoots.
            if (active_q[k] < target_d[k]) begin
               active_d[k] = active_q[k] + 1'b1;
            end else if (active_q[k] > target_d[k]) begin
               active_d[k] = active_q[k] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         active_q <= '0;
      end else begin
         active_q <= active_d;
      end
   end

   assign active = active_q;
`else
   assign active = target_q;
`endif

   // Output compare; pwm lags cnt by one clk.
   always_comb begin
      pwm_d = '0;
      for (int k = 0; k < 3; k++) begin
         pwm_d[k] = enable && (cnt_q < active[k]);
      end
      sync_d = wrap;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pre_q       <= '0;
         cnt_q       <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         target_q    <= '0;
         pwm_q       <= '0;
         sync_q      <= 1'b0;
      end else begin
         pre_q       <= pre_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         target_q    <= target_d;
         pwm_q       <= pwm_d;
         sync_q      <= sync_d;
      end
   end

endmodule
